da_lut_gen: RTL and testbench

DA_LUT_GEN -- requirements
Module: da_lut_gen

---
 rtl/da_lut_gen.sv | 135 +++++++++++++
 tb/tb_da_lut_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/da_lut_gen.sv
// Builds the 8-entry offset-binary coefficient table for a 4-tap distributed-arithmetic MAC.
// One entry per cycle goes into shadow registers; the full table is committed to w1..w8 in a single edge.
module da_lut_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] h1,
    input  logic [7:0] h2,
    input  logic [7:0] h3,
    input  logic [7:0] h4,
    input  logic       load,
    output logic       ready,
    output logic [9:0] w1,
    output logic [9:0] w2,
    output logic [9:0] w3,
    output logic [9:0] w4,
    output logic [9:0] w5,
    output logic [9:0] w6,
    output logic [9:0] w7,
    output logic [9:0] w8,
    output logic       lut_valid,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic [2:0] cnt;
    logic [7:0] c1, c2, c3, c4;
    logic [9:0] shadow [8];
    logic [9:0] lut_q  [8];
    logic [9:0] e1, e2, e3, e4;
    logic [9:0] t2, t3, t4;
    logic [9:0] entry;

    // Counter bit i selects the sign of coefficient i+2; h1 is always added.
    always_comb begin
        e1    = {{2{c1[7]}}, c1};
        e2    = {{2{c2[7]}}, c2};
        e3    = {{2{c3[7]}}, c3};
        e4    = {{2{c4[7]}}, c4};
        t2    = cnt[0] ? (10'd0 - e2) : e2;
        t3    = cnt[1] ? (10'd0 - e3) : e3;
        t4    = cnt[2] ? (10'd0 - e4) : e4;
        entry = e1 + t2 + t3 + t4;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults come first so no path through the case leaves an output unassigned (no latches).
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == 3'd7) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: the shadow and output tables are reset explicitly; a reset mid-pass must not leak stale entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 3'd0;
            c1        <= 8'd0;
            c2        <= 8'd0;
            c3        <= 8'd0;
            c4        <= 8'd0;
            lut_valid <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 10'd0;
                lut_q[i]  <= 10'd0;
            end
        end else begin
            done <= 1'b0;
            if (accept) begin
                c1  <= h1;
                c2  <= h2;
                c3  <= h3;
                c4  <= h4;
                cnt <= 3'd0;
            end
            if (state == CALC) begin
                shadow[cnt] <= entry;
                cnt         <= cnt + 3'd1;
            end
            if (state == COMMIT) begin
                for (int i = 0; i < 8; i++) begin
                    lut_q[i] <= shadow[i];
                end
                done      <= 1'b1;
                lut_valid <= 1'b1;
            end
        end
    end

    assign w1 = lut_q[0];
    assign w2 = lut_q[1];
    assign w3 = lut_q[2];
    assign w4 = lut_q[3];
    assign w5 = lut_q[4];
    assign w6 = lut_q[5];
    assign w7 = lut_q[6];
    assign w8 = lut_q[7];

endmodule

// File: tb/tb_da_lut_gen.sv
// Directed bench for da_lut_gen: latency, commit atomicity, load dropping, mid-pass reset, back-to-back loads.
module tb_da_lut_gen;

    typedef logic [9:0] lut_t [8];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] h1, h2, h3, h4;
    logic       load;
    logic       ready;
    logic [9:0] w1, w2, w3, w4, w5, w6, w7, w8;
    logic       lut_valid;
    logic       done;
    lut_t       wv;

    int checks = 0;
    int errors = 0;

    lut_t tab_a = '{10'd10, 10'd6, 10'd4, 10'd0, 10'd2, 10'h3FE, 10'h3FC, 10'h3F8};
    lut_t zeros = '{default: 10'd0};
    lut_t tab_neg;
    lut_t tab_pos;

    da_lut_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h1        (h1),
        .h2        (h2),
        .h3        (h3),
        .h4        (h4),
        .load      (load),
        .ready     (ready),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .w4        (w4),
        .w5        (w5),
        .w6        (w6),
        .w7        (w7),
        .w8        (w8),
        .lut_valid (lut_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign wv[0] = w1;
    assign wv[1] = w2;
    assign wv[2] = w3;
    assign wv[3] = w4;
    assign wv[4] = w5;
    assign wv[5] = w6;
    assign wv[6] = w7;
    assign wv[7] = w8;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_lut(input string tag, input lut_t exp);
        for (int i = 0; i < 8; i++) begin
            check_w($sformatf("%s_w%0d", tag, i + 1), wv[i], exp[i]);
        end
    endtask

    // Reference table: entry k = a + s0*b + s1*c + s2*d, si = -1 when bit i of k is set.
    function automatic lut_t model(input int a, input int b, input int c, input int d);
        lut_t m;
        int   v;
        for (int k = 0; k < 8; k++) begin
            v = a + (((k & 1) != 0) ? -b : b) + (((k & 2) != 0) ? -c : c)
                  + (((k & 4) != 0) ? -d : d);
            m[k] = v[9:0];
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_h(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        h1 = a;
        h2 = b;
        h3 = c;
        h4 = d;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check_bit({tag, "_done_seen"}, done, 1'b1);
    endtask

    initial begin
        tab_neg = model(-128, -128, -128, -128);
        tab_pos = model(127, 127, 127, 127);

        // Reset values
        rst_n = 1'b0;
        load  = 1'b0;
        set_h(8'd0, 8'd0, 8'd0, 8'd0);
        #1;
        check_bit("rst_ready", ready, 1'b1);
        check_bit("rst_lut_valid", lut_valid, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_lut("rst", zeros);
        tick();
        tick();
        rst_n = 1'b1;

        // Single pass with h = (1,2,3,4); exact 9-cycle latency, table frozen during CALC
        set_h(8'd1, 8'd2, 8'd3, 8'd4);
        load = 1'b1;
        check_bit("p1_ready_idle", ready, 1'b1);
        tick();
        check_bit("p1_ready_after_accept", ready, 1'b0);
        load = 1'b0;
        set_h(8'd9, 8'd9, 8'd9, 8'd9);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_bit($sformatf("p1_done_early_%0d", i), done, 1'b0);
            check_bit($sformatf("p1_valid_early_%0d", i), lut_valid, 1'b0);
            check_lut($sformatf("p1_stable_%0d", i), zeros);
        end
        tick();
        check_bit("p1_done", done, 1'b1);
        check_bit("p1_lut_valid", lut_valid, 1'b1);
        check_bit("p1_ready_back", ready, 1'b1);
        check_lut("p1_table", tab_a);
        tick();
        check_bit("p1_done_low", done, 1'b0);

        // Load during CALC is dropped; changed h after acceptance has no effect
        set_h(8'd1, 8'd2, 8'd3, 8'd4);
        load = 1'b1;
        tick();
        set_h(8'd5, 8'd5, 8'd5, 8'd5);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_bit($sformatf("drop_ready_%0d", i), ready, 1'b0);
        end
        load = 1'b0;
        tick();
        check_bit("drop_done", done, 1'b1);
        check_lut("drop_table", tab_a);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_bit($sformatf("drop_no_requeue_%0d", i), done, 1'b0);
        end
        check_bit("drop_ready_idle", ready, 1'b1);

        // Extreme negative coefficients
        set_h(8'h80, 8'h80, 8'h80, 8'h80);
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_done("neg");
        check_w("neg_w1", w1, 10'h200);
        check_w("neg_w8", w8, 10'd256);
        check_lut("neg_table", tab_neg);

        // Rebuild neg -> pos, sampling every cycle: old table until commit, new table afterwards
        tick();
        set_h(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i < 9) begin
                check_lut($sformatf("atomic_old_%0d", i), tab_neg);
            end else begin
                check_lut($sformatf("atomic_new_%0d", i), tab_pos);
            end
            check_bit($sformatf("atomic_done_%0d", i), done, (i == 9));
        end
        check_w("pos_w1", w1, 10'd508);
        check_w("pos_w8", w8, 10'h302);

        // Reset asserted at counter = 4 of a pass
        set_h(8'd1, 8'd2, 8'd3, 8'd4);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_bit("midrst_ready", ready, 1'b1);
        check_bit("midrst_lut_valid", lut_valid, 1'b0);
        check_bit("midrst_done", done, 1'b0);
        check_lut("midrst", zeros);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_bit($sformatf("midrst_no_done_%0d", i), done, 1'b0);
            check_bit($sformatf("midrst_no_valid_%0d", i), lut_valid, 1'b0);
        end
        check_lut("midrst_after", zeros);

        // Load held high from the first edge after reset release: rebuilds every 10 cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_h(8'd1, 8'd2, 8'd3, 8'd4);
        load = 1'b1;
        for (int i = 0; i < 25; i++) begin
            check_bit($sformatf("b2b_ready_%0d", i), ready, ((i % 10) == 0));
            tick();
            check_bit($sformatf("b2b_done_%0d", i), done, ((i % 10) == 9));
        end
        load = 1'b0;
        wait_done("b2b_last");
        check_lut("b2b_table", tab_a);
        check_bit("b2b_lut_valid", lut_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
